// File: rtl/neuron_state_obi_initiator.sv
// OBI initiator that bulk-fills or bulk-reads the neuron state memory through the neuron core responder port.
// Define NEURON_STATE_CLEAR_ON_READ_EN to write each read word back with its membrane bits [11:0] cleared.
// Bus packing: master_req_o = {req, we, be[3:0], addr[31:0], wdata[31:0]}, master_resp_i = {gnt, rvalid, rdata[31:0]}.
module neuron_state_obi_initiator #(
  parameter int N = 256,
  parameter int M = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         start_i,
  input  logic         mode_i,
  input  logic [31:0]  base_addr_i,
  input  logic [M:0]   count_i,
  input  logic [31:0]  fill_word_i,
  output logic         busy_o,
  output logic         done_o,
  output logic         rd_valid_o,
  input  logic         rd_ready_i,
  output logic [31:0]  rd_data_o,
  output logic [M-1:0] rd_idx_o,
  output logic [69:0]  master_req_o,
  input  logic [33:0]  master_resp_i
);

  localparam logic [M:0] COUNT_MAX = (M+1)'(N);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    DRAIN,
    DONE
`ifdef NEURON_STATE_CLEAR_ON_READ_EN
    ,
    WB_REQ,
    WB_WAIT
`endif
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        mode;
  logic [31:0] base;
  logic [M:0]  count;
  logic [31:0] fill;
  logic [M-1:0] idx;
`ifdef NEURON_STATE_CLEAR_ON_READ_EN
  logic [31:0] wb_data;
`endif

  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        last;
  logic        buf_free;
  logic        advance;
  logic        capture;
  logic        req;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;

  assign gnt      = master_resp_i[33];
  assign rvalid   = master_resp_i[32];
  assign rdata    = master_resp_i[31:0];
  assign last     = ({1'b0, idx} == (count - (M+1)'(1)));
  assign buf_free = !rd_valid_o || rd_ready_i;

  assign busy_o       = (state != IDLE) && (state != DONE);
  assign done_o       = (state == DONE);
  assign master_req_o = {req, we, be, addr, wdata};

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      mode       <= 1'b0;
      base       <= '0;
      count      <= '0;
      fill       <= '0;
      idx        <= '0;
      rd_valid_o <= 1'b0;
      rd_data_o  <= '0;
      rd_idx_o   <= '0;
`ifdef NEURON_STATE_CLEAR_ON_READ_EN
      wb_data    <= '0;
`endif
    end else begin
      state <= state_next;
      if (state == IDLE && start_i) begin
        mode  <= mode_i;
        base  <= base_addr_i;
        count <= (count_i > COUNT_MAX) ? COUNT_MAX : count_i;
        fill  <= fill_word_i;
        idx   <= '0;
      end
      if (advance) idx <= idx + M'(1);
      // A capture always lands on an empty buffer, so it may override the clear below.
      if (rd_valid_o && rd_ready_i) rd_valid_o <= 1'b0;
      if (capture) begin
        rd_valid_o <= 1'b1;
        rd_data_o  <= rdata;
        rd_idx_o   <= idx;
`ifdef NEURON_STATE_CLEAR_ON_READ_EN
        wb_data    <= rdata & 32'hFFFF_F000;
`endif
      end
    end
  end

  always_comb begin
    state_next = state;
    advance    = 1'b0;
    capture    = 1'b0;
    req        = 1'b0;
    we         = 1'b0;
    be         = 4'h0;
    addr       = '0;
    wdata      = '0;
    case (state)
      IDLE: if (start_i) state_next = (count_i == '0) ? DONE : REQ;
      REQ: begin
        addr  = base + 32'(idx);
        we    = ~mode;
        be    = 4'hF;
        wdata = mode ? 32'h0 : fill;
        req   = !mode || buf_free;
        if (req && gnt) state_next = WAIT;
      end
      WAIT: if (rvalid) begin
        capture = mode;
`ifdef NEURON_STATE_CLEAR_ON_READ_EN
        if (mode) state_next = WB_REQ;
        else if (last) state_next = DONE;
        else begin
          advance    = 1'b1;
          state_next = REQ;
        end
`else
        if (last) state_next = mode ? DRAIN : DONE;
        else begin
          advance    = 1'b1;
          state_next = REQ;
        end
`endif
      end
`ifdef NEURON_STATE_CLEAR_ON_READ_EN
      WB_REQ: begin
        addr  = base + 32'(idx);
        we    = 1'b1;
        be    = 4'hF;
        wdata = wb_data;
        req   = 1'b1;
        if (gnt) state_next = WB_WAIT;
      end
      WB_WAIT: if (rvalid) begin
        if (last) state_next = DRAIN;
        else begin
          advance    = 1'b1;
          state_next = REQ;
        end
      end
`endif
      // Hold off completion until the consumer has taken the final word.
      DRAIN: if (buf_free) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_neuron_state_obi_initiator.sv
// Self-checking bench for neuron_state_obi_initiator: OBI memory responder, stream monitor and a range-level reference model.
// Honours NEURON_STATE_CLEAR_ON_READ_EN so the expected bus traffic matches the built variant.
module tb_neuron_state_obi_initiator;

  localparam int N = 256;
  localparam int M = 8;
`ifdef NEURON_STATE_CLEAR_ON_READ_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  typedef struct packed {
    logic [7:0]  idx;
    logic [31:0] data;
  } item_t;

  logic         CLK;
  logic         RST;
  logic         start_i;
  logic         mode_i;
  logic [31:0]  base_addr_i;
  logic [M:0]   count_i;
  logic [31:0]  fill_word_i;
  logic         busy_o;
  logic         done_o;
  logic         rd_valid_o;
  logic         rd_ready_i;
  logic [31:0]  rd_data_o;
  logic [M-1:0] rd_idx_o;
  logic [69:0]  master_req_o;
  logic [33:0]  master_resp_i;

  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        m_req;
  logic        m_we;
  logic [3:0]  m_be;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;

  assign master_resp_i = {gnt, rvalid, rdata};
  assign m_req   = master_req_o[69];
  assign m_we    = master_req_o[68];
  assign m_be    = master_req_o[67:64];
  assign m_addr  = master_req_o[63:32];
  assign m_wdata = master_req_o[31:0];

  neuron_state_obi_initiator #(.N(N), .M(M)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .start_i      (start_i),
    .mode_i       (mode_i),
    .base_addr_i  (base_addr_i),
    .count_i      (count_i),
    .fill_word_i  (fill_word_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .rd_valid_o   (rd_valid_o),
    .rd_ready_i   (rd_ready_i),
    .rd_data_o    (rd_data_o),
    .rd_idx_o     (rd_idx_o),
    .master_req_o (master_req_o),
    .master_resp_i(master_resp_i)
  );

  int errors = 0;
  int checks = 0;
  int cycle_cnt = 0;
  int start_cyc = 0;
  int req_cycles = 0;
  int gnt_stall = 0;
  int stall_left = 0;
  int resp_lat = 1;
  int lat_cnt = 0;
  int ready_mode = 0;
  logic [31:0] pend_data;
  logic        holding;
  logic [31:0] hold_addr;
  logic [31:0] hold_wdata;

  logic [31:0] mem [256];
  logic [31:0] model_mem [256];
  txn_t  txn_q[$];
  txn_t  exp_txn[$];
  item_t stream_q[$];
  item_t exp_stream[$];

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cycle_cnt <= cycle_cnt + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Memory responder: grant after gnt_stall waiting cycles, rvalid resp_lat cycles after the grant.
  initial begin
    gnt = 1'b1; rvalid = 1'b0; rdata = '0; pend_data = '0; holding = 1'b0;
    hold_addr = '0; hold_wdata = '0;
    forever begin
      @(posedge CLK); #1;
      rvalid = 1'b0;
      rdata  = '0;
      if (lat_cnt > 0) begin
        lat_cnt--;
        if (lat_cnt == 0) begin
          rvalid = 1'b1;
          rdata  = pend_data;
        end
      end
      gnt = (stall_left == 0);
      @(negedge CLK);
      if (m_req) begin
        req_cycles++;
        if (holding) begin
          checkOutput("hold_addr", m_addr, hold_addr);
          checkOutput("hold_wdata", m_wdata, hold_wdata);
        end
        if (gnt) begin
          txn_q.push_back({m_we, m_be, m_addr, m_wdata});
          if (m_we) begin
            mem[m_addr[7:0]] = m_wdata;
            pend_data = '0;
          end else begin
            pend_data = mem[m_addr[7:0]];
          end
          lat_cnt    = resp_lat;
          stall_left = gnt_stall;
          holding    = 1'b0;
        end else begin
          if (stall_left > 0) stall_left--;
          holding    = 1'b1;
          hold_addr  = m_addr;
          hold_wdata = m_wdata;
        end
      end else begin
        holding = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge CLK);
      if (rd_valid_o && rd_ready_i) stream_q.push_back({rd_idx_o, rd_data_o});
    end
  end

  initial begin
    rd_ready_i = 1'b1;
    forever begin
      @(posedge CLK); #1;
      case (ready_mode)
        0: rd_ready_i = 1'b1;
        1: rd_ready_i = 1'($urandom % 2);
        default: rd_ready_i = 1'b0;
      endcase
    end
  end

  task automatic tick();
    @(posedge CLK); #2;
  endtask

  task automatic setMem(input logic [31:0] a, input logic [31:0] v);
    mem[a[7:0]] = v;
    model_mem[a[7:0]] = v;
  endtask

  task automatic clearLogs();
    txn_q.delete();
    stream_q.delete();
  endtask

  // Reference: one bus access per entry k at base+k, reads stream (k, word), optional clearing write-back.
  task automatic buildExpected(input logic md, input logic [31:0] b, input int cnt, input logic [31:0] fw);
    int n;
    logic [31:0] a;
    logic [31:0] word;
    exp_txn.delete();
    exp_stream.delete();
    n = (cnt > N) ? N : cnt;
    for (int k = 0; k < n; k++) begin
      a = b + 32'(k);
      if (!md) begin
        exp_txn.push_back({1'b1, 4'hF, a, fw});
        model_mem[a[7:0]] = fw;
      end else begin
        word = model_mem[a[7:0]];
        exp_txn.push_back({1'b0, 4'hF, a, 32'h0});
        exp_stream.push_back({8'(k), word});
        if (CLR) begin
          exp_txn.push_back({1'b1, 4'hF, a, word & 32'hFFFF_F000});
          model_mem[a[7:0]] = word & 32'hFFFF_F000;
        end
      end
    end
  endtask

  task automatic compareAll(input string tag);
    int mism = 0;
    checkOutput({tag, "_ntxn"}, 32'(txn_q.size()), 32'(exp_txn.size()));
    for (int i = 0; i < txn_q.size() && i < exp_txn.size(); i++) begin
      checkOutput({tag, "_addr"}, txn_q[i].addr, exp_txn[i].addr);
      checkOutput({tag, "_wdata"}, txn_q[i].wdata, exp_txn[i].wdata);
      checkOutput({tag, "_webe"}, {27'd0, txn_q[i].we, txn_q[i].be}, {27'd0, exp_txn[i].we, exp_txn[i].be});
    end
    checkOutput({tag, "_nstream"}, 32'(stream_q.size()), 32'(exp_stream.size()));
    for (int i = 0; i < stream_q.size() && i < exp_stream.size(); i++) begin
      checkOutput({tag, "_sidx"}, {24'd0, stream_q[i].idx}, {24'd0, exp_stream[i].idx});
      checkOutput({tag, "_sdata"}, stream_q[i].data, exp_stream[i].data);
    end
    for (int a = 0; a < 256; a++) if (mem[a] !== model_mem[a]) mism++;
    checkOutput({tag, "_mem"}, 32'(mism), 32'd0);
  endtask

  task automatic applyStimulus(input logic md, input logic [31:0] b, input logic [M:0] cnt, input logic [31:0] fw);
    mode_i      = md;
    base_addr_i = b;
    count_i     = cnt;
    fill_word_i = fw;
    start_i     = 1'b1;
    start_cyc   = cycle_cnt;
    tick();
    start_i = 1'b0;
  endtask

  task automatic waitDone(input string tag, input int budget, output int latency);
    int n = 0;
    while (!done_o && n < budget) begin
      tick();
      n++;
    end
    checkOutput({tag, "_done"}, 32'(done_o), 32'd1);
    latency = cycle_cnt - start_cyc;
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_busy"}, 32'(busy_o), 32'd0);
    checkOutput({tag, "_doneo"}, 32'(done_o), 32'd0);
    checkOutput({tag, "_rdvalid"}, 32'(rd_valid_o), 32'd0);
    checkOutput({tag, "_rddata"}, rd_data_o, 32'd0);
    checkOutput({tag, "_rdidx"}, 32'(rd_idx_o), 32'd0);
    checkOutput({tag, "_reqctl"}, {26'd0, master_req_o[69:64]}, 32'd0);
    checkOutput({tag, "_reqaddr"}, master_req_o[63:32], 32'd0);
    checkOutput({tag, "_reqwdata"}, master_req_o[31:0], 32'd0);
  endtask

  initial begin
    int lat;
    int n;
    int rc;
    logic md;
    logic [31:0] b;
    logic [31:0] fw;
    int cnt;

    RST = 1'b1; start_i = 1'b0; mode_i = 1'b0; base_addr_i = '0; count_i = '0; fill_word_i = '0;
    for (int a = 0; a < 256; a++) begin
      mem[a] = '0;
      model_mem[a] = '0;
    end
    tick();
    tick();
    checkIdleOutputs("reset");
    RST = 1'b0;
    tick();

    $display("[TB] FILL base=0 count=4");
    clearLogs();
    buildExpected(1'b0, 32'h0, 4, 32'h8A0F_A000);
    applyStimulus(1'b0, 32'h0, 9'd4, 32'h8A0F_A000);
    checkOutput("fill_busy", 32'(busy_o), 32'd1);
    waitDone("fill", 50, lat);
    checkOutput("fill_latency", 32'(lat), 32'd9);
    tick();
    checkOutput("fill_idle", 32'(busy_o), 32'd0);
    compareAll("fill");

    $display("[TB] READ base=0x10 count=3");
    setMem(32'h10, 32'h11); setMem(32'h11, 32'h22); setMem(32'h12, 32'h33);
    clearLogs();
    buildExpected(1'b1, 32'h10, 3, 32'h0);
    applyStimulus(1'b1, 32'h10, 9'd3, 32'h0);
    waitDone("read", 50, lat);
    checkOutput("read_valid_at_done", 32'(rd_valid_o), 32'd0);
    tick();
    compareAll("read");

    $display("[TB] READ with stream backpressure");
    setMem(32'h10, 32'h11); setMem(32'h11, 32'h22); setMem(32'h12, 32'h33);
    ready_mode = 2;
    clearLogs();
    buildExpected(1'b1, 32'h10, 3, 32'h0);
    applyStimulus(1'b1, 32'h10, 9'd3, 32'h0);
    n = 0;
    while (!rd_valid_o && n < 20) begin
      tick();
      n++;
    end
    checkOutput("bp_first_valid", 32'(rd_valid_o), 32'd1);
    rc = req_cycles;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("bp_hold_valid", 32'(rd_valid_o), 32'd1);
      checkOutput("bp_hold_data", rd_data_o, 32'h11);
      checkOutput("bp_hold_idx", 32'(rd_idx_o), 32'd0);
    end
    checkOutput("bp_no_req", 32'(req_cycles - rc), CLR ? 32'd1 : 32'd0);
    ready_mode = 0;
    waitDone("bp", 50, lat);
    checkOutput("bp_valid_at_done", 32'(rd_valid_o), 32'd0);
    tick();
    compareAll("bp");

    $display("[TB] grant held low for 3 cycles");
    gnt_stall = 3; stall_left = 3;
    clearLogs();
    buildExpected(1'b0, 32'h40, 1, 32'hCAFE_F00D);
    rc = req_cycles;
    applyStimulus(1'b0, 32'h40, 9'd1, 32'hCAFE_F00D);
    waitDone("stall", 50, lat);
    checkOutput("stall_latency", 32'(lat), 32'd6);
    tick();
    checkOutput("stall_req_cycles", 32'(req_cycles - rc), 32'd4);
    compareAll("stall");
    gnt_stall = 0; stall_left = 0;

    $display("[TB] count=0");
    clearLogs();
    buildExpected(1'b0, 32'h50, 0, 32'h1234);
    rc = req_cycles;
    applyStimulus(1'b0, 32'h50, 9'd0, 32'h1234);
    checkOutput("zero_done", 32'(done_o), 32'd1);
    checkOutput("zero_busy", 32'(busy_o), 32'd0);
    tick();
    checkOutput("zero_done_pulse", 32'(done_o), 32'd0);
    checkOutput("zero_no_req", 32'(req_cycles - rc), 32'd0);
    compareAll("zero");

    $display("[TB] start pulsed while busy");
    clearLogs();
    buildExpected(1'b0, 32'h80, 4, 32'h5A5A_5A5A);
    applyStimulus(1'b0, 32'h80, 9'd4, 32'h5A5A_5A5A);
    tick();
    tick();
    mode_i = 1'b1; base_addr_i = 32'h10; count_i = 9'd2; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    waitDone("busystart", 50, lat);
    checkOutput("busystart_latency", 32'(lat), 32'd9);
    tick();
    tick();
    tick();
    checkOutput("busystart_idle", 32'(busy_o), 32'd0);
    compareAll("busystart");

    $display("[TB] count clamp and address wrap");
    clearLogs();
    buildExpected(1'b0, 32'hFFFF_FF80, 300, 32'h1357_9BDF);
    applyStimulus(1'b0, 32'hFFFF_FF80, 9'd300, 32'h1357_9BDF);
    waitDone("clamp", 700, lat);
    checkOutput("clamp_latency", 32'(lat), 32'd513);
    tick();
    compareAll("clamp");

`ifdef NEURON_STATE_CLEAR_ON_READ_EN
    $display("[TB] READ with clear-on-read write-back");
    setMem(32'h20, 32'h8A0F_A123);
    clearLogs();
    buildExpected(1'b1, 32'h20, 1, 32'h0);
    applyStimulus(1'b1, 32'h20, 9'd1, 32'h0);
    waitDone("clr", 50, lat);
    tick();
    compareAll("clr");
    checkOutput("clr_entry", mem[8'h20], 32'h8A0F_A000);
    checkOutput("clr_stream_word", (stream_q.size() > 0) ? stream_q[0].data : 32'h0, 32'h8A0F_A123);
`endif

    $display("[TB] randomized operations");
    for (int r = 0; r < 8; r++) begin
      md  = 1'($urandom % 2);
      b   = $urandom;
      cnt = $urandom_range(1, 6);
      fw  = $urandom;
      gnt_stall  = $urandom_range(0, 2);
      stall_left = gnt_stall;
      resp_lat   = $urandom_range(1, 2);
      ready_mode = 1;
      if (md) for (int k = 0; k < cnt; k++) setMem(b + 32'(k), $urandom);
      clearLogs();
      buildExpected(md, b, cnt, fw);
      applyStimulus(md, b, 9'(cnt), fw);
      waitDone("rand", 200, lat);
      tick();
      tick();
      compareAll("rand");
    end
    ready_mode = 0; gnt_stall = 0; stall_left = 0;

    $display("[TB] reset while waiting for rvalid");
    resp_lat = 2;
    setMem(32'h10, 32'h11); setMem(32'h11, 32'h22); setMem(32'h12, 32'h33);
    clearLogs();
    applyStimulus(1'b1, 32'h10, 9'd3, 32'h0);
    n = 0;
    while (txn_q.size() == 0 && n < 20) begin
      tick();
      n++;
    end
    checkOutput("rstwait_handshake", 32'(txn_q.size()), 32'd1);
    RST = 1'b1;
    tick();
    checkIdleOutputs("rstwait");
    RST = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("rstwait_stray_valid", 32'(rd_valid_o), 32'd0);
    end
    checkOutput("rstwait_stream", 32'(stream_q.size()), 32'd0);
    resp_lat = 1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/neuron_state_obi_initiator.md
Name: neuron_state_obi_initiator

Overview:
- OBI initiator (manager) that bulk-accesses the neuron state memory through the neuron core's OBI responder port.
- FILL mode writes one programmed 32-bit word into a contiguous range of neuron entries. Used to initialise the enable, leak, threshold and core-state fields.
- READ mode reads a range of entries and streams them out over a valid/ready port for readout or debug.
- Sits between the system/config logic and the neuron core's OBI slave port; it is the only master on that port while busy.

Parameters:
- N, 256, number of neuron entries addressable.
- M, 8, neuron index width; log2(N).
- req_t, logic, OBI request struct type (req, we, be, addr, wdata).
- rsp_t, logic, OBI response struct type (gnt, rvalid, rdata).

Ports:
- CLK  in  1  clock.
- RST  in  1  reset. Synchronous, active-high.
- start_i  in  1  one-cycle pulse; starts an operation when idle.
- mode_i  in  1  0 = FILL, 1 = READ. Sampled on the accepted start.
- base_addr_i  in  32  OBI address of the first entry. Word index sits in the low bits: entry k is at address base_addr_i + k.
- count_i  in  M+1  number of entries to access. Sampled on start.
- fill_word_i  in  32  data written in FILL mode. Sampled on start.
- busy_o  out  1  high from the cycle after an accepted start until done.
- done_o  out  1  one-cycle pulse when the operation completes.
- rd_valid_o  out  1  read stream: data valid.
- rd_ready_i  in  1  read stream: consumer ready.
- rd_data_o  out  32  read stream: neuron state word.
- rd_idx_o  out  M  read stream: entry offset k of rd_data_o.
- master_req_o  out  req_t  OBI request to the neuron core.
- master_resp_i  in  rsp_t  OBI response from the neuron core.

Behaviour:
- Reset values: busy_o=0, done_o=0, rd_valid_o=0, rd_data_o=0, rd_idx_o=0, all master_req_o fields 0, FSM=IDLE, idx=0.
- Start acceptance:
  - start_i is accepted only in IDLE; it is ignored while busy.
  - On acceptance, mode, base, count and fill word are latched. count is clamped to N.
  - count=0: done_o pulses the cycle after start, busy_o stays 0, no bus traffic.
- States: IDLE -> REQ -> WAIT -> (REQ | DONE) -> IDLE.
- REQ:
  - req=1; be=4'hF; addr=base+idx; we=~mode; wdata=fill_word (FILL) or 0 (READ).
  - addr, we and wdata are held stable until gnt=1.
  - In the gnt cycle, FSM moves to WAIT. req is 0 in WAIT.
- WAIT:
  - Waits for rvalid. Any latency of 1 or more cycles after gnt is accepted; the neuron core gives exactly 1.
  - Only one transaction is outstanding at a time.
  - FILL: on rvalid, rdata is ignored.
  - READ: on rvalid, rdata and idx are captured into the single-entry output buffer and rd_valid_o is set.
  - After rvalid: if idx==count-1, go to DONE; otherwise idx++ and go to REQ.
- READ backpressure:
  - REQ for the next entry is not asserted while rd_valid_o=1 and rd_ready_i=0 (buffer full).
  - The buffer clears on rd_valid_o & rd_ready_i. A new request may assert in that same cycle.
- DONE:
  - done_o=1 for one cycle, then IDLE.
  - In READ mode, DONE is entered only after the last word has been accepted on the stream. rd_valid_o is therefore 0 when done_o pulses.
- Throughput: FILL with a 1-cycle rvalid responder takes 2 cycles per entry. done_o asserts 2*count+1 cycles after start.
- Address arithmetic: 32-bit unsigned, wraps modulo 2^32. idx never exceeds count-1.
- Stray rvalid (rvalid seen outside WAIT, e.g. from a transaction cut off by reset): ignored; no stream output.
- Reset mid-operation: next cycle all outputs return to reset values, including req=0, even if gnt has not arrived.

Optional Feature:
- Macro: NEURON_STATE_CLEAR_ON_READ_EN.
- Defined:
  - In READ mode, after each read's rvalid the FSM enters WB_REQ/WB_WAIT.
  - It writes back to the same address the read word with bits [11:0] (membrane state) cleared; bits [31:12] are unchanged.
  - Same handshake rules as REQ/WAIT. idx advances only after the write-back rvalid.
  - The stream still outputs the original, uncleared word.
  - Per-entry cost is 4 cycles with a 1-cycle responder.
- Not defined: the WB states do not exist; READ is read-only.

Test Plan:
- FILL, base=0x0, count=4, fill_word=0x8A0FA000, 1-cycle responder -> writes to addr 0..3 with be=F and wdata=0x8A0FA000; memory entries 0..3 read 0x8A0FA000; done_o 9 cycles after start.
- READ, base=0x10, count=3, memory[0x10..0x12]=0x11,0x22,0x33, rd_ready_i=1 -> stream (0,0x11),(1,0x22),(2,0x33); done_o after the last word is accepted.
- READ with rd_ready_i=0 for 5 cycles after the first word -> rd_valid_o stays high with 0x11 held; no second req until the handshake completes.
- Responder holding gnt=0 for 3 cycles -> req, addr and wdata stable for all 4 cycles; one transfer only.
- count=0 -> done_o pulses the next cycle with no req. start_i pulsed while busy -> ignored. RST asserted in WAIT -> req=0, busy_o=0 next cycle; the late rvalid produces no stream output.
- With NEURON_STATE_CLEAR_ON_READ_EN, READ of entry holding 0x8A0FA123 -> stream shows 0x8A0FA123; entry then reads 0x8A0FA000.
